magma_iter_coder: RTL and testbench
===================================

# magma_iter_coder

Iterative, parametrised GOST 28147-89 / Magma 64-bit block cipher core. Successor to the fixed 32-stage coder pipeline: runtime-loadable 256-bit key, per-block encrypt/decrypt selection and a configurable number of rounds unrolled per clock. It trades throughput for area and sits between two stream interfaces in the encryptor datapath.

## Interface
- ROUNDS_PER_CYCLE, 1: rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16, 32; any other value is an elaboration error.
- TDATA_WIDTH, 64: block width; fixed by the algorithm, and any value other than 64 is an elaboration error.
- KEY_WIDTH, 256: key width; any value other than 256 is an elaboration error.
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- key_i  in  256  key; round key Ki = key_i[255-32i -: 32], i = 0..7
- key_valid_i  in  1  key write strobe; honoured only in IDLE
- key_loaded_o  out  1  a valid key is present
- ss_tvalid_i  in  1  input block valid
- ss_tdata_i  in  64  input block; n1 = [31:0], n2 = [63:32]
- ss_tuser_i  in  1  mode: 0 = encrypt, 1 = decrypt; sampled with the block
- ss_tready_o  out  1  core can accept a block
- sm_tvalid_o  out  1  output block valid
- sm_tdata_o  out  64  output block
- sm_tready_i  in  1  downstream ready
- busy_o  out  1  state is not IDLE

## Operation
- States:
  - IDLE: accept a block or a key.
  - RUN: process rounds.
  - OUT: present the result.
- Ready and key-write rules in IDLE:
  - ss_tready_o = (state == IDLE) && key_loaded_o && !key_valid_i.
  - A key write in IDLE takes priority over a block in the same cycle; the block waits.
  - key_valid_i outside IDLE is ignored; the key register is unchanged.
- IDLE→RUN on ss_tvalid_i && ss_tready_o:
  - load n1/n2 from ss_tdata_i;
  - latch mode from ss_tuser_i;
  - clear the round counter.
- RUN, per cycle:
  - apply ROUNDS_PER_CYCLE rounds;
  - the counter advances by ROUNDS_PER_CYCLE, modulo 32;
  - on the cycle finishing round 31, go to OUT.
- Round r (0..31):
  - t = sbox(n1 + K mod 2^32), rol 11; n1' = n2 ^ t; n2' = n1.
  - Round 31 does not swap: n2' = n2 ^ t; n1' = n1.
- Key index, encrypt: r < 24 ? r%8 : 7 - r%8.
- Key index, decrypt: r < 8 ? r%8 : 7 - r%8.
- OUT:
  - sm_tvalid_o = 1; sm_tdata_o = {n2, n1}.
  - Output is held stable until sm_tready_i, then the core goes to IDLE.
- Reset:
  - Reset in any state forces IDLE and discards the in-flight block.
  - The key register reloads per the Configuration section.
- Reset values:
  - sm_tvalid_o 0; sm_tdata_o 0; busy_o 0; ss_tready_o 0 while rst_i is high.
  - key_loaded_o as set by the Configuration section.

## Timing
- Let N = 32 / ROUNDS_PER_CYCLE.
- sm_tvalid_o rises N cycles after the accepting clock edge. With ROUNDS_PER_CYCLE = 1, that is 32 cycles.
- Throughput with sm_tready_i held high: one block per N+2 cycles (accept, N RUN cycles, OUT).
- All outputs are registered, except ss_tready_o, which is combinational on key_valid_i.
- The new key applies from the first block accepted after the key_valid_i cycle.
- Backpressure: OUT persists indefinitely; ss_tready_o stays 0 throughout.

## Configuration
- MAGMA_DEFAULT_KEY_EN defined:
  - reset loads 256'h96696996_69969669_69969669_96696996_69969669_96696996_96696996_69969669;
  - key_loaded_o = 1 out of reset.
- MAGMA_DEFAULT_KEY_EN undefined:
  - reset loads 0; key_loaded_o = 0;
  - ss_tready_o stays 0 until the first key_valid_i in IDLE.

## Structure
- Package magma_pkg holds:
  - the S-box constant (id-tc26-gost-28147-param-Z, 8×16×4);
  - DEFAULT_KEY;
  - the state enum;
  - the key-index function;
  - the sbox/rol11 function.
- Sub-module magma_round: one combinational round, with a final-round (no swap) input.
- The core instantiates ROUNDS_PER_CYCLE copies of magma_round in a generate chain, plus the FSM, counter and registers.

## Test plan
- Key ffeeddcc_bbaa9988_77665544_33221100_f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff, encrypt fedcba9876543210 -> 4ee901e5c2d8ca3d after 32 cycles (ROUNDS_PER_CYCLE = 1).
- Same key, decrypt 4ee901e5c2d8ca3d -> fedcba9876543210. Repeat with ROUNDS_PER_CYCLE = 4 and 32: identical data; latency 8 and 1 cycles.
- Hold sm_tready_i = 0 for 10 cycles in OUT -> sm_tdata_o stable, ss_tready_o = 0, then one handshake and back to IDLE.
- key_valid_i and ss_tvalid_i high together in IDLE -> key written, block not accepted that cycle and accepted on the next cycle with the new key. key_valid_i during RUN -> ignored.
- rst_i pulsed mid-RUN -> next cycle busy_o = 0, sm_tvalid_o = 0, no output for the discarded block. key_loaded_o: 1 if MAGMA_DEFAULT_KEY_EN, else 0 with ss_tready_o = 0.
- Back-to-back blocks with sm_tready_i = 1 -> one output every N+2 cycles, order preserved, mixed encrypt/decrypt modes honoured per block.

Source files
------------

// File: rtl/magma_pkg.sv
// magma_pkg: shared constants and helpers for the Magma / GOST 28147-89 coder.
// Holds the S-box, the build-time default key, the FSM state codes, the
// round-key schedule and the combined substitute-and-rotate function.
package magma_pkg;

    localparam int BLOCK_WIDTH = 64;
    localparam int KEY_BITS    = 256;
    localparam int NUM_ROUNDS  = 32;

    // S-box id-tc26-gost-28147-param-Z. Row j substitutes nibble j of the
    // word (row 0 = least significant nibble); entry v of a row sits at
    // bits [63-4v -: 4] of that row.
    localparam logic [0:7][63:0] SBOX = {
        64'hc462a5b9e8d703f1,
        64'h68239a5c1e47bd0f,
        64'hb3582fade174c960,
        64'hc821d4f670a53e9b,
        64'h7f5a816d093eb42c,
        64'h5df692cab78143e0,
        64'h8e25691cf4b0da37,
        64'h17ed05834fa69cb2
    };

    // Key loaded by reset when the default-key build option is enabled.
    localparam logic [KEY_BITS-1:0] DEFAULT_KEY =
        256'h96696996_69969669_69969669_96696996_69969669_96696996_96696996_69969669;

    // FSM state codes, kept as plain constants so older netlists and
    // debug scripts that match on the raw encoding keep working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_OUT  = 2'b10;

    // Round-key index for round r. Encryption walks K0..K7 three times and
    // then K7..K0; decryption walks K0..K7 once and then K7..K0 three times.
    // 7 - r%8 is simply the bitwise complement of the low three bits.
    function automatic logic [2:0] key_index(input logic [4:0] r, input logic decrypt);
        logic forward;
        forward = decrypt ? (r < 5'd8) : (r < 5'd24);
        return forward ? r[2:0] : ~r[2:0];
    endfunction

    // Substitute all eight nibbles through their S-box row, then rotate
    // the 32-bit result left by 11.
    function automatic logic [31:0] g_func(input logic [31:0] a);
        logic [31:0] s;
        int          v;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            v            = int'(a[4*j +: 4]);
            s[4*j +: 4]  = SBOX[j][63-4*v -: 4];
        end
        return {s[20:0], s[31:21]};
    endfunction

endpackage

// File: rtl/magma_round.sv
// magma_round: one combinational Magma Feistel round. The final-round input
// suppresses the half swap so that the last round leaves n1 in place and
// folds the round function into n2.
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    input  logic [31:0] round_key,
    input  logic        final_round,
    output logic [31:0] n1_next,
    output logic [31:0] n2_next
);

    logic [31:0] t;

    // Round function on the key-mixed n1 half (addition is modulo 2^32).
    always_comb begin
        t = g_func(n1 + round_key);
    end

    // Feistel step: swap halves on every round except the last one.
    always_comb begin
        // NOTE: both outputs get a value before the if, so no path leaves
        // them unassigned and no latch is inferred.
        n1_next = n2 ^ t;
        n2_next = n1;
        if (final_round) begin
            n1_next = n1;
            n2_next = n2 ^ t;
        end
    end

endmodule

// File: rtl/magma_iter_coder.sv
// magma_iter_coder: iterative Magma / GOST 28147-89 64-bit block cipher core
// with a runtime-loadable 256-bit key, per-block encrypt/decrypt selection
// and ROUNDS_PER_CYCLE rounds unrolled per clock (32/ROUNDS_PER_CYCLE RUN
// cycles per block).
//
// Build option MAGMA_DEFAULT_KEY_EN: when defined, reset loads DEFAULT_KEY
// and key_loaded_o is 1 out of reset. When undefined, reset clears the key,
// key_loaded_o is 0 and no block is accepted until the first key write.
module magma_iter_coder
    import magma_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TDATA_WIDTH      = 64,
    parameter int KEY_WIDTH        = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic                   key_valid_i,
    output logic                   key_loaded_o,
    input  logic                   ss_tvalid_i,
    input  logic [TDATA_WIDTH-1:0] ss_tdata_i,
    input  logic                   ss_tuser_i,
    output logic                   ss_tready_o,
    output logic                   sm_tvalid_o,
    output logic [TDATA_WIDTH-1:0] sm_tdata_o,
    input  logic                   sm_tready_i,
    output logic                   busy_o
);

    // ------------------------------------------------------------------
    // Parameter legality: anything outside the supported set is rejected
    // at elaboration rather than producing a silently wrong cipher.
    // ------------------------------------------------------------------
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
        $error("magma_iter_coder: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end
    if (TDATA_WIDTH != BLOCK_WIDTH) begin : g_bad_tdata
        $error("magma_iter_coder: TDATA_WIDTH must be 64");
    end
    if (KEY_WIDTH != KEY_BITS) begin : g_bad_key
        $error("magma_iter_coder: KEY_WIDTH must be 256");
    end

    // Counter step (modulo 32, so 32 rounds per cycle steps by zero) and the
    // counter value seen on the RUN cycle that completes round 31.
    localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE % NUM_ROUNDS);
    localparam logic [4:0] CNT_LAST = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

`ifdef MAGMA_DEFAULT_KEY_EN
    localparam logic [KEY_WIDTH-1:0] RESET_KEY        = DEFAULT_KEY;
    localparam logic                 RESET_KEY_LOADED = 1'b1;
`else
    localparam logic [KEY_WIDTH-1:0] RESET_KEY        = '0;
    localparam logic                 RESET_KEY_LOADED = 1'b0;
`endif

    state_t                 state;
    logic [31:0]            n1;
    logic [31:0]            n2;
    logic                   mode;
    logic [4:0]             round_cnt;
    logic [KEY_WIDTH-1:0]   key_reg;
    logic                   key_loaded;
    logic                   out_valid;
    logic [TDATA_WIDTH-1:0] out_data;
    logic [31:0]            key_words [8];
    logic [31:0]            n1_last;
    logic [31:0]            n2_last;
    logic                   accept;

    // Split the key register into the eight 32-bit round keys, K0 on top.
    for (genvar i = 0; i < 8; i++) begin : g_key_word
        assign key_words[i] = key_reg[KEY_WIDTH-1-32*i -: 32];
    end

    // ------------------------------------------------------------------
    // Unrolled round chain. Stage k evaluates round round_cnt + k; each
    // stage owns its output halves so the chain is a straight pipeline of
    // distinct nets.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [4:0]  round_num;
        logic [2:0]  key_sel;
        logic [31:0] round_key;
        logic        last_round;
        logic [31:0] n1_in;
        logic [31:0] n2_in;
        logic [31:0] n1_out;
        logic [31:0] n2_out;

        assign round_num  = round_cnt + 5'(k);
        assign key_sel    = key_index(round_num, mode);
        assign round_key  = key_words[key_sel];
        assign last_round = (round_num == 5'd31);

        if (k == 0) begin : g_first
            assign n1_in = n1;
            assign n2_in = n2;
        end else begin : g_chain
            assign n1_in = g_round[k-1].n1_out;
            assign n2_in = g_round[k-1].n2_out;
        end

        magma_round u_round (
            .n1          (n1_in),
            .n2          (n2_in),
            .round_key   (round_key),
            .final_round (last_round),
            .n1_next     (n1_out),
            .n2_next     (n2_out)
        );
    end

    assign n1_last = g_round[ROUNDS_PER_CYCLE-1].n1_out;
    assign n2_last = g_round[ROUNDS_PER_CYCLE-1].n2_out;

    // ------------------------------------------------------------------
    // Handshake. A key write in IDLE masks ready, which gives the key
    // priority over a block presented in the same cycle.
    // ------------------------------------------------------------------
    assign ss_tready_o  = !rst_i && (state == ST_IDLE) && key_loaded && !key_valid_i;
    assign accept       = ss_tvalid_i && ss_tready_o;

    assign key_loaded_o = key_loaded;
    assign sm_tvalid_o  = out_valid;
    assign sm_tdata_o   = out_data;
    assign busy_o       = (state != ST_IDLE);

    // FSM, round counter, working halves, key register and output register.
    always_ff @(posedge clk_i) begin
        // NOTE: every register here is written with non-blocking assignments
        // so all of them update from pre-edge values in the same clock.
        if (rst_i) begin
            // NOTE: the working halves are cleared on reset as well so a
            // discarded block leaves no residue; the key register follows the
            // build option.
            state      <= ST_IDLE;
            n1         <= '0;
            n2         <= '0;
            mode       <= 1'b0;
            round_cnt  <= '0;
            key_reg    <= RESET_KEY;
            key_loaded <= RESET_KEY_LOADED;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid_i) begin
                        key_reg    <= key_i;
                        key_loaded <= 1'b1;
                    end else if (accept) begin
                        n1        <= ss_tdata_i[31:0];
                        n2        <= ss_tdata_i[63:32];
                        mode      <= ss_tuser_i;
                        round_cnt <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    n1        <= n1_last;
                    n2        <= n2_last;
                    round_cnt <= round_cnt + CNT_STEP;
                    if (round_cnt == CNT_LAST) begin
                        out_valid <= 1'b1;
                        out_data  <= {n2_last, n1_last};
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (sm_tready_i) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magma_iter_coder.sv
// tb_magma_iter_coder: self-checking bench for magma_iter_coder. Three cores
// (1, 4 and 32 rounds per clock) share clock, reset, key and downstream
// ready; each has its own upstream stream and outputs. Expected blocks come
// from a plain Feistel model with its own key schedule and S-box table.
module tb_magma_iter_coder;

    localparam int NU = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic [255:0] key_i;
    logic         key_valid_i;
    logic         sm_tready_i;

    logic         ss_tvalid  [NU];
    logic [63:0]  ss_tdata   [NU];
    logic         ss_tuser   [NU];
    logic         ss_tready  [NU];
    logic         sm_tvalid  [NU];
    logic [63:0]  sm_tdata   [NU];
    logic         busy       [NU];
    logic         key_loaded [NU];

    int           total = 0;
    int           bad   = 0;
    logic [255:0] model_key;

`ifdef MAGMA_DEFAULT_KEY_EN
    localparam logic EXP_LOADED = 1'b1;
`else
    localparam logic EXP_LOADED = 1'b0;
`endif

    localparam logic [255:0] KV_KEY =
        256'hffeeddcc_bbaa9988_77665544_33221100_f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff;

    for (genvar i = 0; i < NU; i++) begin : g_dut
        localparam int R = (i == 0) ? 1 : ((i == 1) ? 4 : 32);
        magma_iter_coder #(.ROUNDS_PER_CYCLE(R)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst_i),
            .key_i        (key_i),
            .key_valid_i  (key_valid_i),
            .key_loaded_o (key_loaded[i]),
            .ss_tvalid_i  (ss_tvalid[i]),
            .ss_tdata_i   (ss_tdata[i]),
            .ss_tuser_i   (ss_tuser[i]),
            .ss_tready_o  (ss_tready[i]),
            .sm_tvalid_o  (sm_tvalid[i]),
            .sm_tdata_o   (sm_tdata[i]),
            .sm_tready_i  (sm_tready_i),
            .busy_o       (busy[i])
        );
    end

    // ---------------- reference model ----------------
    int pi [8][16] = '{
        '{12, 4, 6, 2, 10, 5, 11, 9, 14, 8, 13, 7, 0, 3, 15, 1},
        '{6, 8, 2, 3, 9, 10, 5, 12, 1, 14, 4, 7, 11, 13, 0, 15},
        '{11, 3, 5, 8, 2, 15, 10, 13, 14, 1, 7, 4, 12, 9, 6, 0},
        '{12, 8, 2, 1, 13, 4, 15, 6, 7, 0, 10, 5, 3, 14, 9, 11},
        '{7, 15, 5, 10, 8, 1, 6, 13, 0, 9, 3, 14, 11, 4, 2, 12},
        '{5, 13, 15, 6, 9, 2, 12, 10, 11, 7, 8, 1, 4, 3, 14, 0},
        '{8, 14, 2, 5, 6, 9, 1, 12, 15, 4, 11, 0, 13, 10, 3, 7},
        '{1, 7, 14, 13, 0, 5, 8, 3, 4, 15, 10, 6, 9, 12, 11, 2}
    };

    function automatic logic [31:0] ref_g(input logic [31:0] a);
        logic [31:0] s;
        for (int j = 0; j < 8; j++) s[4*j +: 4] = 4'(pi[j][a[4*j +: 4]]);
        return (s << 11) | (s >> 21);
    endfunction

    // Encryption schedule K0..K7 x3 then K7..K0; decryption is its reverse.
    function automatic logic [63:0] ref_cipher(input logic [255:0] k, input logic [63:0] blk,
                                               input logic dec);
        logic [31:0] kw [8];
        logic [31:0] sched [32];
        logic [31:0] a1, a0, tmp, rk;
        for (int i = 0; i < 8; i++) kw[i] = k[255-32*i -: 32];
        for (int i = 0; i < 32; i++) sched[i] = (i < 24) ? kw[i % 8] : kw[31 - i];
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            rk = dec ? sched[31 - i] : sched[i];
            if (i < 31) begin
                tmp = a0;
                a0  = a1 ^ ref_g(a0 + rk);
                a1  = tmp;
            end else begin
                a1 = a1 ^ ref_g(a0 + rk);
            end
        end
        return {a1, a0};
    endfunction

    function automatic int lat_of(input int u);
        int rpc;
        rpc = (u == 0) ? 1 : ((u == 1) ? 4 : 32);
        return 32 / rpc;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic write_key(input logic [255:0] k);
        @(negedge clk);
        key_i       = k;
        key_valid_i = 1'b1;
        @(negedge clk);
        key_valid_i = 1'b0;
        model_key   = k;
    endtask

    task automatic accept_block(input int u, input logic [63:0] d, input logic dec);
        int w;
        w = 0;
        while (ss_tready[u] !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) begin
            total++; bad++;
            $display("FAIL accept_timeout u%0d: ss_tready_o=%b required 1", u, ss_tready[u]);
        end
        ss_tvalid[u] = 1'b1;
        ss_tdata[u]  = d;
        ss_tuser[u]  = dec;
        @(negedge clk);
        ss_tvalid[u] = 1'b0;
    endtask

    task automatic collect(input int u, output logic [63:0] q, output int lat);
        lat = 0;
        while (sm_tvalid[u] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            total++; bad++;
            $display("FAIL collect_timeout u%0d: sm_tvalid_o=%b required 1", u, sm_tvalid[u]);
        end
        q = sm_tdata[u];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            total++;
            if (ss_tready[u] !== 1'b0) begin bad++; $display("FAIL rst_tready u%0d: got %b want 0", u, ss_tready[u]); end
            total++;
            if (sm_tvalid[u] !== 1'b0) begin bad++; $display("FAIL rst_tvalid u%0d: got %b want 0", u, sm_tvalid[u]); end
            total++;
            if (busy[u] !== 1'b0) begin bad++; $display("FAIL rst_busy u%0d: got %b want 0", u, busy[u]); end
            total++;
            if (sm_tdata[u] !== 64'h0) begin bad++; $display("FAIL rst_tdata u%0d: got %h want 0", u, sm_tdata[u]); end
            total++;
            if (key_loaded[u] !== EXP_LOADED) begin bad++; $display("FAIL rst_key_loaded u%0d: got %b want %b", u, key_loaded[u], EXP_LOADED); end
        end
        rst_i = 1'b0;
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            total++;
            if (ss_tready[u] !== EXP_LOADED) begin bad++; $display("FAIL post_rst_tready u%0d: got %b want %b", u, ss_tready[u], EXP_LOADED); end
        end
`ifndef MAGMA_DEFAULT_KEY_EN
        ss_tvalid[0] = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL no_key_accept: busy_o=%b want 0", busy[0]); end
        ss_tvalid[0] = 1'b0;
`endif
    endtask

    task automatic test_known_vector();
        logic [63:0] q;
        int          lat;
        write_key(KV_KEY);
        for (int u = 0; u < NU; u++) begin
            accept_block(u, 64'hfedcba9876543210, 1'b0);
            collect(u, q, lat);
            total++;
            if (q !== 64'h4ee901e5c2d8ca3d) begin bad++; $display("FAIL kv_encrypt u%0d: got %h want 4ee901e5c2d8ca3d", u, q); end
            total++;
            if (lat !== lat_of(u)) begin bad++; $display("FAIL kv_enc_latency u%0d: got %0d want %0d", u, lat, lat_of(u)); end
            accept_block(u, 64'h4ee901e5c2d8ca3d, 1'b1);
            collect(u, q, lat);
            total++;
            if (q !== 64'hfedcba9876543210) begin bad++; $display("FAIL kv_decrypt u%0d: got %h want fedcba9876543210", u, q); end
            total++;
            if (lat !== lat_of(u)) begin bad++; $display("FAIL kv_dec_latency u%0d: got %0d want %0d", u, lat, lat_of(u)); end
        end
    endtask

    task automatic test_random();
        logic [63:0] d, q, e;
        logic        dec;
        int          lat, u;
        for (int it = 0; it < 9; it++) begin
            u   = it % NU;
            d   = rand64();
            dec = 1'($urandom_range(0, 1));
            write_key(rand256());
            e = ref_cipher(model_key, d, dec);
            accept_block(u, d, dec);
            collect(u, q, lat);
            total++;
            if (q !== e) begin bad++; $display("FAIL random u%0d dec=%b: got %h want %h", u, dec, q, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, q, e;
        int          lat;
        d = rand64();
        e = ref_cipher(model_key, d, 1'b0);
        sm_tready_i = 1'b0;
        accept_block(0, d, 1'b0);
        collect(0, q, lat);
        total++;
        if (q !== e) begin bad++; $display("FAIL bp_data: got %h want %h", q, e); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (sm_tdata[0] !== e || sm_tvalid[0] !== 1'b1 || ss_tready[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c%0d: data=%h valid=%b tready=%b want %h 1 0", c, sm_tdata[0], sm_tvalid[0], ss_tready[0], e);
            end
        end
        sm_tready_i = 1'b1;
        @(negedge clk);
        total++;
        if (sm_tvalid[0] !== 1'b0 || busy[0] !== 1'b0 || ss_tready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b busy=%b tready=%b want 0 0 1", sm_tvalid[0], busy[0], ss_tready[0]);
        end
    endtask

    task automatic test_key_collision();
        logic [255:0] knew;
        logic [63:0]  d, q, e;
        int           lat;
        knew = rand256();
        d    = rand64();
        e    = ref_cipher(knew, d, 1'b0);
        @(negedge clk);
        key_i        = knew;
        key_valid_i  = 1'b1;
        ss_tvalid[0] = 1'b1;
        ss_tdata[0]  = d;
        ss_tuser[0]  = 1'b0;
        #1;
        total++;
        if (ss_tready[0] !== 1'b0) begin bad++; $display("FAIL coll_tready: got %b want 0", ss_tready[0]); end
        @(negedge clk);
        key_valid_i = 1'b0;
        #1;
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL coll_not_accepted: busy_o=%b want 0", busy[0]); end
        total++;
        if (ss_tready[0] !== 1'b1) begin bad++; $display("FAIL coll_tready_next: got %b want 1", ss_tready[0]); end
        @(negedge clk);
        ss_tvalid[0] = 1'b0;
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL coll_accepted: busy_o=%b want 1", busy[0]); end
        model_key = knew;
        collect(0, q, lat);
        total++;
        if (q !== e) begin bad++; $display("FAIL coll_new_key: got %h want %h", q, e); end
    endtask

    task automatic test_key_during_run();
        logic [255:0] kold;
        logic [63:0]  d, q, e;
        int           lat;
        kold = model_key;
        d    = rand64();
        e    = ref_cipher(kold, d, 1'b1);
        accept_block(0, d, 1'b1);
        repeat (5) @(negedge clk);
        key_i       = rand256();
        key_valid_i = 1'b1;
        @(negedge clk);
        key_valid_i = 1'b0;
        collect(0, q, lat);
        total++;
        if (q !== e) begin bad++; $display("FAIL run_key_inflight: got %h want %h", q, e); end
        d = rand64();
        e = ref_cipher(kold, d, 1'b0);
        accept_block(0, d, 1'b0);
        collect(0, q, lat);
        total++;
        if (q !== e) begin bad++; $display("FAIL run_key_kept: got %h want %h", q, e); end
        write_key(kold);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        accept_block(0, rand64(), 1'b0);
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b0 || sm_tvalid[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_state: busy=%b valid=%b want 0 0", busy[0], sm_tvalid[0]);
        end
        total++;
        if (ss_tready[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_tready: got %b want 0", ss_tready[0]); end
        total++;
        if (key_loaded[0] !== EXP_LOADED) begin bad++; $display("FAIL mid_rst_key_loaded: got %b want %b", key_loaded[0], EXP_LOADED); end
        rst_i = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sm_tvalid[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_output: saw sm_tvalid_o=1, want none"); end
`ifndef MAGMA_DEFAULT_KEY_EN
        total++;
        if (ss_tready[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_no_key_tready: got %b want 0", ss_tready[0]); end
`endif
        write_key(model_key);
    endtask

    task automatic test_back_to_back(input int u);
        logic [63:0] blk [5];
        logic        md  [5];
        logic [63:0] exp_q [$];
        logic [63:0] e;
        int          n, idx, outs, last, cyc;
        bit          pend;
        n    = lat_of(u);
        idx  = 0;
        outs = 0;
        last = -1;
        cyc  = 0;
        pend = 1'b0;
        for (int i = 0; i < 5; i++) begin
            blk[i] = rand64();
            md[i]  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ss_tdata[u]  = blk[0];
        ss_tuser[u]  = md[0];
        ss_tvalid[u] = 1'b1;
        while (outs < 5 && cyc < 5 * (n + 2) + 40) begin
            #1;
            if (sm_tvalid[u] === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                total++;
                if (sm_tdata[u] !== e) begin bad++; $display("FAIL b2b_data u%0d #%0d: got %h want %h", u, outs, sm_tdata[u], e); end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== n + 2) begin bad++; $display("FAIL b2b_spacing u%0d #%0d: got %0d want %0d", u, outs, cyc - last, n + 2); end
                end
                last = cyc;
                outs++;
            end
            if (ss_tvalid[u] === 1'b1 && ss_tready[u] === 1'b1) begin
                exp_q.push_back(ref_cipher(model_key, blk[idx], md[idx]));
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 5) begin
                    ss_tdata[u] = blk[idx];
                    ss_tuser[u] = md[idx];
                end else begin
                    ss_tvalid[u] = 1'b0;
                end
            end
        end
        ss_tvalid[u] = 1'b0;
        total++;
        if (outs !== 5) begin bad++; $display("FAIL b2b_count u%0d: got %0d outputs want 5", u, outs); end
    endtask

    // Bound on total run time in case the design stops responding entirely.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        key_i       = '0;
        key_valid_i = 1'b0;
        sm_tready_i = 1'b1;
        model_key   = '0;
        for (int u = 0; u < NU; u++) begin
            ss_tvalid[u] = 1'b0;
            ss_tdata[u]  = '0;
            ss_tuser[u]  = 1'b0;
        end
        test_reset();
        test_known_vector();
        test_random();
        test_backpressure();
        test_key_collision();
        test_key_during_run();
        test_reset_mid_run();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
